rand_stall_scheduler: RTL and testbench

Synthesizable random-stall injector for up to NumChannels independent valid/ready channels. It sits between a producer and a consumer in bgpu unit and integration benches, or in debug builds of the core. Per channel, after each accepted handshake it closes the channel for a pseudo-random number of cycles in [MinWaitCycles, MaxWaitCycles], then reopens it. A channel that is open is never closed before its handshake completes, so valid is never retracted.

---
 rtl/rand_stall_if.sv | 24 ++
 rtl/rand_stall_scheduler.sv | 147 ++++++++++++++
 tb/tb_rand_stall_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_stall_if.sv
// rand_stall_if: the producer/consumer valid-ready bundle passing through rand_stall_scheduler.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface rand_stall_if #(
  parameter int unsigned NumChannels = 4
);
  logic [NumChannels-1:0] src_valid_i;
  logic [NumChannels-1:0] src_ready_o;
  logic [NumChannels-1:0] dst_valid_o;
  logic [NumChannels-1:0] dst_ready_i;

  modport slave (
    input  src_valid_i,
    input  dst_ready_i,
    output src_ready_o,
    output dst_valid_o
  );

  modport master (
    output src_valid_i,
    output dst_ready_i,
    input  src_ready_o,
    input  dst_valid_o
  );
endinterface

// File: rtl/rand_stall_scheduler.sv
// rand_stall_scheduler: closes each valid/ready channel for a pseudo-random number of cycles after every beat.
// Optional macro RAND_STALL_STATS_EN builds per-channel saturating stall-cycle counters.
module rand_stall_scheduler #(
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned MinWaitCycles = 0,
  parameter int unsigned MaxWaitCycles = 8,
  parameter logic [31:0] LfsrSeed      = 32'hACE1_2024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  rand_stall_if.slave                  chan,
  output logic [NumChannels-1:0][31:0] stall_cycles_o
);

  localparam logic [31:0] LfsrMask   = 32'h8020_0003;
  localparam int unsigned DelayRange = MaxWaitCycles - MinWaitCycles + 1;
  localparam logic [7:0]  MinWait    = 8'(MinWaitCycles);

  typedef enum logic {
    StOpen = 1'b0,
    StWait = 1'b1
  } state_e;

  localparam state_e ResetState = (MinWaitCycles == 0) ? StOpen : StWait;

  logic [31:0]            lfsr_q;
  logic [31:0]            lfsr_d;
  state_e                 state_q [NumChannels];
  state_e                 state_d [NumChannels];
  logic [7:0]             cnt_q   [NumChannels];
  logic [7:0]             cnt_d   [NumChannels];
  logic [7:0]             delay   [NumChannels];
  logic [NumChannels-1:0] handshake;
  logic [NumChannels-1:0] chan_open;

  // Each channel sees its own byte-rotated view of the shared LFSR so that
  // channels handshaking in the same cycle do not draw identical delays.
  function automatic logic [7:0] draw_delay(input logic [31:0] v, input int unsigned ch);
    int unsigned sh;
    logic [31:0] rot;
    logic [15:0] slice;
    sh    = (8 * ch) % 32;
    rot   = (v << sh) | (v >> (32 - sh));
    slice = 16'(rot);
    return MinWait + 8'(slice % 16'(DelayRange));
  endfunction

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrMask : 32'h0);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NumChannels; i++) begin
      delay[i]     = draw_delay(lfsr_q, i);
      handshake[i] = chan.src_valid_i[i] & chan.dst_ready_i[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
      for (int unsigned i = 0; i < NumChannels; i++) begin
        state_q[i] <= ResetState;
        cnt_q[i]   <= MinWait;
      end
    end else begin
      lfsr_q <= lfsr_d;
      for (int unsigned i = 0; i < NumChannels; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // OPEN is only left on a completed handshake, so a forwarded valid is never withdrawn.
  always_comb begin
    for (int unsigned i = 0; i < NumChannels; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!en_i) begin
        state_d[i] = StOpen;
        cnt_d[i]   = 8'd0;
      end else begin
        case (state_q[i])
          StOpen: begin
            if (handshake[i] && (delay[i] != 8'd0)) begin
              state_d[i] = StWait;
              cnt_d[i]   = delay[i];
            end
          end
          StWait: begin
            if (cnt_q[i] <= 8'd1) begin
              state_d[i] = StOpen;
              cnt_d[i]   = 8'd0;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          default: begin
            state_d[i] = StOpen;
            cnt_d[i]   = 8'd0;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NumChannels; i++) begin
      chan_open[i] = !en_i || (state_q[i] == StOpen);
    end
    chan.dst_valid_o = chan.src_valid_i & chan_open;
    chan.src_ready_o = chan.dst_ready_i & chan_open;
  end

`ifdef RAND_STALL_STATS_EN
  logic [NumChannels-1:0][31:0] stall_q;
  logic [NumChannels-1:0][31:0] stall_d;

  // Only cycles where the producer is actually being held back count as stalls.
  always_comb begin
    stall_d = stall_q;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      if (en_i && (state_q[i] == StWait) && chan.src_valid_i[i] && (stall_q[i] != 32'hFFFF_FFFF)) begin
        stall_d[i] = stall_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_rand_stall_scheduler.sv
// Directed self-checking bench for rand_stall_scheduler; one DUT instance per wait-cycle configuration.
module tb_rand_stall_scheduler;

`ifdef RAND_STALL_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  localparam logic [31:0] Seed = 32'hACE1_2024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_main = 1'b1;
  logic en_ctl = 1'b1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rand_stall_if #(.NumChannels(4)) if_min3 ();
  rand_stall_if #(.NumChannels(4)) if_fix2 ();
  rand_stall_if #(.NumChannels(4)) if_zero ();
  rand_stall_if #(.NumChannels(4)) if_en ();
  rand_stall_if #(.NumChannels(4)) if_rand ();

  logic [3:0][31:0] stall_min3;
  logic [3:0][31:0] stall_fix2;
  logic [3:0][31:0] stall_zero;
  logic [3:0][31:0] stall_en;
  logic [3:0][31:0] stall_rand;

  rand_stall_scheduler #(.NumChannels(4), .MinWaitCycles(3), .MaxWaitCycles(8), .LfsrSeed(Seed)) u_min3 (
    .clk_i(clk), .rst_i(rst), .en_i(en_main), .chan(if_min3), .stall_cycles_o(stall_min3));
  rand_stall_scheduler #(.NumChannels(4), .MinWaitCycles(2), .MaxWaitCycles(2), .LfsrSeed(Seed)) u_fix2 (
    .clk_i(clk), .rst_i(rst), .en_i(en_main), .chan(if_fix2), .stall_cycles_o(stall_fix2));
  rand_stall_scheduler #(.NumChannels(4), .MinWaitCycles(0), .MaxWaitCycles(0), .LfsrSeed(Seed)) u_zero (
    .clk_i(clk), .rst_i(rst), .en_i(en_main), .chan(if_zero), .stall_cycles_o(stall_zero));
  rand_stall_scheduler #(.NumChannels(4), .MinWaitCycles(5), .MaxWaitCycles(5), .LfsrSeed(Seed)) u_en (
    .clk_i(clk), .rst_i(rst), .en_i(en_ctl), .chan(if_en), .stall_cycles_o(stall_en));
  rand_stall_scheduler #(.NumChannels(4), .MinWaitCycles(1), .MaxWaitCycles(7), .LfsrSeed(Seed)) u_rand (
    .clk_i(clk), .rst_i(rst), .en_i(en_main), .chan(if_rand), .stall_cycles_o(stall_rand));

  function automatic logic [31:0] lfsr_adv(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int k = 0; k < n; k++) begin
      r = (r >> 1) ^ (r[0] ? 32'h8020_0003 : 32'h0);
    end
    return r;
  endfunction

  // Leaves the caller in the first cycle after reset release (cycle 1).
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_v;
    if_min3.src_valid_i = 4'hF;
    if_min3.dst_ready_i = 4'hF;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (if_min3.dst_valid_o !== 4'h0) begin
      fails++; $display("[TB] FAIL reset_dst_valid: got %h expected %h", if_min3.dst_valid_o, 4'h0);
    end
    tests++;
    if (if_min3.src_ready_o !== 4'h0) begin
      fails++; $display("[TB] FAIL reset_src_ready: got %h expected %h", if_min3.src_ready_o, 4'h0);
    end
    tests++;
    if (stall_min3 !== '0) begin
      fails++; $display("[TB] FAIL reset_stall: got %h expected 0", stall_min3);
    end
    tests++;
    if (u_en.lfsr_q !== Seed) begin
      fails++; $display("[TB] FAIL reset_lfsr: got %h expected %h", u_en.lfsr_q, Seed);
    end
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      exp_v = (c == 4) ? 4'hF : 4'h0;
      tests++;
      if (if_min3.dst_valid_o !== exp_v) begin
        fails++; $display("[TB] FAIL reset_release_c%0d: got %h expected %h", c, if_min3.dst_valid_o, exp_v);
      end
    end
  endtask

  task automatic test_fixed_wait();
    logic exp_v;
    if_fix2.src_valid_i = 4'b0001;
    if_fix2.dst_ready_i = 4'b0001;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      exp_v = ((c % 3) == 0);
      tests++;
      if (if_fix2.dst_valid_o[0] !== exp_v) begin
        fails++; $display("[TB] FAIL fixed_wait_c%0d: got %b expected %b", c, if_fix2.dst_valid_o[0], exp_v);
      end
    end
    tests++;
    if (stall_fix2[0] !== (StatsOn ? 32'd20 : 32'd0)) begin
      fails++; $display("[TB] FAIL fixed_wait_stats0: got %0d expected %0d", stall_fix2[0], StatsOn ? 20 : 0);
    end
    tests++;
    if (stall_fix2[1] !== 32'd0) begin
      fails++; $display("[TB] FAIL fixed_wait_stats1_novalid: got %0d expected 0", stall_fix2[1]);
    end
  endtask

  task automatic test_hold_rule();
    logic exp_v;
    if_fix2.src_valid_i = 4'b0010;
    if_fix2.dst_ready_i = 4'b0000;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge clk);
      if_fix2.dst_ready_i = (c == 13) ? 4'b0010 : 4'b0000;
      #1;
      exp_v = ((c >= 3) && (c <= 13)) || (c == 16);
      tests++;
      if (if_fix2.dst_valid_o[1] !== exp_v) begin
        fails++; $display("[TB] FAIL hold_rule_c%0d: got %b expected %b", c, if_fix2.dst_valid_o[1], exp_v);
      end
      if (c == 13) begin
        tests++;
        if (if_fix2.src_ready_o[1] !== 1'b1) begin
          fails++; $display("[TB] FAIL hold_rule_accept: got %b expected 1", if_fix2.src_ready_o[1]);
        end
      end
    end
    tests++;
    if (stall_fix2[1] !== (StatsOn ? 32'd4 : 32'd0)) begin
      fails++; $display("[TB] FAIL hold_rule_stats: got %0d expected %0d", stall_fix2[1], StatsOn ? 4 : 0);
    end
  endtask

  task automatic test_back_to_back();
    int beats;
    if_zero.src_valid_i = 4'hF;
    if_zero.dst_ready_i = 4'hF;
    do_reset();
    beats = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      tests++;
      if ((if_zero.dst_valid_o !== 4'hF) || (if_zero.src_ready_o !== 4'hF)) begin
        fails++; $display("[TB] FAIL back_to_back_c%0d: got valid %h ready %h expected F F", c, if_zero.dst_valid_o, if_zero.src_ready_o);
      end
      if (if_zero.dst_valid_o[0] && if_zero.dst_ready_i[0]) beats++;
    end
    tests++;
    if (beats != 100) begin
      fails++; $display("[TB] FAIL back_to_back_beats: got %0d expected 100", beats);
    end
    tests++;
    if (stall_zero !== '0) begin
      fails++; $display("[TB] FAIL back_to_back_stats: got %h expected 0", stall_zero);
    end
  endtask

  task automatic test_enable();
    logic exp_v;
    if_en.src_valid_i = 4'b0001;
    if_en.dst_ready_i = 4'b0000;
    en_ctl = 1'b1;
    do_reset();
    en_ctl = 1'b0;
    #1;
    tests++;
    if (if_en.dst_valid_o[0] !== 1'b1) begin
      fails++; $display("[TB] FAIL enable_transparent_c1: got %b expected 1", if_en.dst_valid_o[0]);
    end
    @(negedge clk);
    #1;
    tests++;
    if (if_en.dst_valid_o[0] !== 1'b1) begin
      fails++; $display("[TB] FAIL enable_transparent_c2: got %b expected 1", if_en.dst_valid_o[0]);
    end
    @(negedge clk);
    en_ctl = 1'b1;
    #1;
    tests++;
    if (if_en.dst_valid_o[0] !== 1'b1) begin
      fails++; $display("[TB] FAIL enable_reopen_c3: got %b expected 1", if_en.dst_valid_o[0]);
    end
    tests++;
    if (u_en.lfsr_q !== Seed) begin
      fails++; $display("[TB] FAIL enable_lfsr_frozen: got %h expected %h", u_en.lfsr_q, Seed);
    end
    for (int c = 4; c <= 12; c++) begin
      @(negedge clk);
      if_en.dst_ready_i = (c == 6) ? 4'b0001 : 4'b0000;
      #1;
      exp_v = !((c >= 7) && (c <= 11));
      tests++;
      if (if_en.dst_valid_o[0] !== exp_v) begin
        fails++; $display("[TB] FAIL enable_wait_c%0d: got %b expected %b", c, if_en.dst_valid_o[0], exp_v);
      end
      if (c == 4) begin
        tests++;
        if (u_en.lfsr_q !== lfsr_adv(Seed, 1)) begin
          fails++; $display("[TB] FAIL enable_lfsr_resume: got %h expected %h", u_en.lfsr_q, lfsr_adv(Seed, 1));
        end
      end
    end
    tests++;
    if (u_en.lfsr_q !== lfsr_adv(Seed, 9)) begin
      fails++; $display("[TB] FAIL enable_lfsr_nine: got %h expected %h", u_en.lfsr_q, lfsr_adv(Seed, 9));
    end
    tests++;
    if (stall_en[0] !== (StatsOn ? 32'd5 : 32'd0)) begin
      fails++; $display("[TB] FAIL enable_stats: got %0d expected %0d", stall_en[0], StatsOn ? 5 : 0);
    end
  endtask

  task automatic test_random_gaps();
    int gap [4];
    int hist [4][8];
    int src_beats [4];
    int dst_beats [4];
    int closed_cnt [4];
    bit measuring [4];
    bit pending [4];
    int total;
    int cyc;
    int missing;
    logic dv, dr, sr;
    for (int i = 0; i < 4; i++) begin
      gap[i] = 0; src_beats[i] = 0; dst_beats[i] = 0; closed_cnt[i] = 0;
      measuring[i] = 1'b0; pending[i] = 1'b0;
      for (int v = 0; v < 8; v++) hist[i][v] = 0;
    end
    if_rand.src_valid_i = 4'hF;
    if_rand.dst_ready_i = 4'h0;
    do_reset();
    total = 0;
    cyc = 0;
    while ((total < 10000) && (cyc < 60000)) begin
      if (cyc > 0) @(negedge clk);
      for (int i = 0; i < 4; i++) if_rand.dst_ready_i[i] = ($urandom_range(0, 3) != 0);
      #1;
      for (int i = 0; i < 4; i++) begin
        dv = if_rand.dst_valid_o[i];
        dr = if_rand.dst_ready_i[i];
        sr = if_rand.src_ready_o[i];
        if (!dv) closed_cnt[i]++;
        if (pending[i]) begin
          tests++;
          if (dv !== 1'b1) begin
            fails++; $display("[TB] FAIL random_hold_ch%0d cyc %0d: got %b expected 1", i, cyc, dv);
          end
        end
        if (measuring[i]) begin
          if (!dv) gap[i]++;
          else begin
            measuring[i] = 1'b0;
            tests++;
            if ((gap[i] < 1) || (gap[i] > 7)) begin
              fails++; $display("[TB] FAIL random_gap_ch%0d cyc %0d: got %0d expected 1..7", i, cyc, gap[i]);
            end else begin
              hist[i][gap[i]]++;
            end
          end
        end
        if (sr) src_beats[i]++;
        if (dv && dr) begin
          dst_beats[i]++;
          total++;
          measuring[i] = 1'b1;
          gap[i] = 0;
        end
        pending[i] = dv && !dr;
      end
      cyc++;
    end
    tests++;
    if (total < 10000) begin
      fails++; $display("[TB] FAIL random_timeout: got %0d beats expected 10000", total);
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (src_beats[i] != dst_beats[i]) begin
        fails++; $display("[TB] FAIL random_scoreboard_ch%0d: got src %0d dst %0d expected equal", i, src_beats[i], dst_beats[i]);
      end
      missing = 0;
      for (int v = 1; v <= 7; v++) if (hist[i][v] == 0) missing++;
      tests++;
      if (missing != 0) begin
        fails++; $display("[TB] FAIL random_coverage_ch%0d: got %0d gap values missing expected 0", i, missing);
      end
      tests++;
      if (stall_rand[i] !== (StatsOn ? 32'(closed_cnt[i]) : 32'd0)) begin
        fails++; $display("[TB] FAIL random_stats_ch%0d: got %0d expected %0d", i, stall_rand[i], StatsOn ? closed_cnt[i] : 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    if_min3.src_valid_i = '0; if_min3.dst_ready_i = '0;
    if_fix2.src_valid_i = '0; if_fix2.dst_ready_i = '0;
    if_zero.src_valid_i = '0; if_zero.dst_ready_i = '0;
    if_en.src_valid_i   = '0; if_en.dst_ready_i   = '0;
    if_rand.src_valid_i = '0; if_rand.dst_ready_i = '0;
    test_reset();
    test_fixed_wait();
    test_hold_rule();
    test_back_to_back();
    test_enable();
    test_random_gaps();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
